// File: rtl/seq_accum_pkg.sv
// Shared types and helpers for the burst
// accumulate-and-echo block.
package seq_accum_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_OUT
  } state_t;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_XOR = 2'd3;

  // Wide enough for a full burst sum
  function automatic int calc_out_w(
    input int dw,
    input int depth
  );
    return dw + $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational burst reduction step:
// sum, max, min or xor of acc and sample.
module accum_alu
  import seq_accum_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int OUT_W  = 6
) (
  input  logic [OUT_W-1:0]  acc,
  input  logic [DATA_W-1:0] sample,
  input  logic [1:0]        mode,
  output logic [OUT_W-1:0]  res
);

  logic [DATA_W-1:0] lo;

  // Non-sum modes keep the value in the low bits
  assign lo = acc[DATA_W-1:0];

  always_comb begin
    res = '0;
    unique case (1'b1)
      (mode == MODE_SUM):
        res = acc + OUT_W'(sample);
      (mode == MODE_MAX):
        res = OUT_W'((lo > sample) ? lo : sample);
      (mode == MODE_MIN):
        res = OUT_W'((lo < sample) ? lo : sample);
      (mode == MODE_XOR):
        res = OUT_W'(lo ^ sample);
      default:
        res = '0;
    endcase
  end

endmodule

// File: rtl/seq_accum_echo.sv
// Captures a burst, replays it in order,
// then emits the reduced result word.
module seq_accum_echo
  import seq_accum_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 5,
  parameter int OUT_W  = calc_out_w(DATA_W, DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] INPUT,
  input  logic [1:0]        MODE,
  output logic [OUT_W-1:0]  OUT,
  output logic              OUT_VALID,
  output logic              OVF,
  output logic              BUSY
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count;
  logic [CW-1:0]     idx;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  alu_res;
  logic [1:0]        mode_q;
  logic              ovf_flag;
  logic              done;

  accum_alu #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_alu (
    .acc    (acc),
    .sample (INPUT),
    .mode   (mode_q),
    .res    (alu_res)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      count     <= '0;
      idx       <= '0;
      acc       <= '0;
      mode_q    <= MODE_SUM;
      ovf_flag  <= 1'b0;
      done      <= 1'b0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      OVF       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            mem[0]   <= INPUT;
            count    <= CW'(1);
            mode_q   <= MODE;
            acc      <= OUT_W'(INPUT);
            ovf_flag <= 1'b0;
            BUSY     <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (IN_VALID) begin
            if (count < CW'(DEPTH)) begin
              mem[IW'(count)] <= INPUT;
              count <= count + 1'b1;
              acc   <= alu_res;
            end else begin
              ovf_flag <= 1'b1;
            end
          end else begin
            idx   <= '0;
            done  <= 1'b0;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          // One extra cycle after the result drops valid and busy
          if (done) begin
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OVF       <= 1'b0;
            BUSY      <= 1'b0;
            count     <= '0;
            idx       <= '0;
            done      <= 1'b0;
            state     <= S_IDLE;
          end else if (idx < count) begin
            OUT       <= OUT_W'(mem[IW'(idx)]);
            OUT_VALID <= 1'b1;
            idx       <= idx + 1'b1;
          end else begin
            OUT       <= acc;
            OVF       <= ovf_flag;
            OUT_VALID <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_accum_echo.sv
// Directed checks for seq_accum_echo at
// default and wide parameter sets.
module tb_seq_accum_echo;

  logic        clk;
  logic        rst;
  logic        iv_a;
  logic [2:0]  in_a;
  logic [1:0]  mode_a;
  logic [5:0]  out_a;
  logic        ov_a;
  logic        ovf_a;
  logic        busy_a;

  logic        iv_b;
  logic [7:0]  in_b;
  logic [1:0]  mode_b;
  logic [12:0] out_b;
  logic        ov_b;
  logic        ovf_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;
  int vin[$];
  int vexp[$];

  seq_accum_echo dut_a (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (iv_a),
    .INPUT     (in_a),
    .MODE      (mode_a),
    .OUT       (out_a),
    .OUT_VALID (ov_a),
    .OVF       (ovf_a),
    .BUSY      (busy_a)
  );

  seq_accum_echo #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut_b (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (iv_b),
    .INPUT     (in_b),
    .MODE      (mode_b),
    .OUT       (out_b),
    .OUT_VALID (ov_b),
    .OVF       (ovf_b),
    .BUSY      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Drives vin into dut_a, then checks vexp words
  task automatic run_a(
    input string      tag,
    input logic [1:0] mode,
    input logic       ovf_exp,
    input logic       toggle
  );
    for (int i = 0; i < vin.size(); i++) begin
      iv_a   = 1'b1;
      in_a   = 3'(vin[i]);
      mode_a = (toggle && i > 0) ? ~mode : mode;
      step();
      chk({tag, " busy_in"}, 32'(busy_a), 1);
    end
    iv_a   = 1'b0;
    in_a   = 3'd0;
    mode_a = 2'd0;
    step();
    chk({tag, " gap_valid"}, 32'(ov_a), 0);
    for (int k = 0; k < vexp.size(); k++) begin
      step();
      chk({tag, " valid"}, 32'(ov_a), 1);
      chk({tag, " word"}, 32'(out_a), 32'(vexp[k]));
      chk({tag, " ovf"}, 32'(ovf_a),
          (k == vexp.size() - 1) ? 32'(ovf_exp) : 0);
      chk({tag, " busy_out"}, 32'(busy_a), 1);
    end
    step();
    chk({tag, " end_valid"}, 32'(ov_a), 0);
    chk({tag, " end_out"}, 32'(out_a), 0);
    chk({tag, " end_busy"}, 32'(busy_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    iv_a = 1'b0; in_a = '0; mode_a = '0;
    iv_b = 1'b0; in_b = '0; mode_b = '0;
    step();
    step();
    chk("rst_out", 32'(out_a), 0);
    chk("rst_valid", 32'(ov_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    rst = 1'b0;

    vin  = '{1, 2, 3, 4, 5};
    vexp = '{1, 2, 3, 4, 5, 15};
    run_a("sum5", 2'd0, 1'b0, 1'b0);

    vin  = '{7, 7, 7, 7, 7, 7, 7};
    vexp = '{7, 7, 7, 7, 7, 35};
    run_a("ovf7", 2'd0, 1'b1, 1'b0);

    vin  = '{3, 6, 1};
    vexp = '{3, 6, 1, 6};
    run_a("max", 2'd1, 1'b0, 1'b1);
    vexp = '{3, 6, 1, 1};
    run_a("min", 2'd2, 1'b0, 1'b1);

    vin  = '{5};
    vexp = '{5, 5};
    run_a("xor1", 2'd3, 1'b0, 1'b0);

    vin  = '{6, 5, 3};
    vexp = '{6, 5, 3, 0};
    run_a("xor3", 2'd3, 1'b0, 1'b0);

    // Reset lands in the third output cycle
    for (int i = 1; i <= 3; i++) begin
      iv_a = 1'b1;
      in_a = 3'(i);
      step();
    end
    iv_a = 1'b0;
    step();
    step();
    step();
    step();
    chk("pre_rst_word", 32'(out_a), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out", 32'(out_a), 0);
    chk("mid_rst_valid", 32'(ov_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    vin  = '{2, 2};
    vexp = '{2, 2, 4};
    run_a("post_rst", 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      iv_b = 1'b1;
      in_b = 8'd255;
      step();
    end
    iv_b = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      chk("wide_word", 32'(out_b), 255);
    end
    step();
    chk("wide_valid", 32'(ov_b), 1);
    chk("wide_sum", 32'(out_b), 4080);
    chk("wide_ovf", 32'(ovf_b), 0);
    step();
    chk("wide_end", 32'(ov_b), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
